// File: rtl/uart_bus_responder.sv
// ============================================================================
// Module   : uart_bus_responder
// Purpose  : Bus-side UART responder. Answers CPU serial-port accesses made
//            through rdn/wrn strobes on the shared RAM1 data bus, transmits
//            from a one-byte holding register through an 8N1 shift register,
//            and buffers received 8N1 bytes in a small FIFO.
// Config   : `define UART_RESP_LOOPBACK_EN routes internal txd into the
//            receiver instead of the rxd pin (txd pin still toggles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bus_responder #(
   parameter int CLKS_PER_BIT = 434,   // even, >= 4
   parameter int RX_DEPTH     = 4      // power of 2, >= 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       rdn,
   input  logic       wrn,
   input  logic [7:0] bus_data_in,
   output logic [7:0] bus_data_out,
   output logic       bus_data_oe,
   output logic       data_ready,
   output logic       tbre,
   output logic       tsre,
   output logic       rx_overrun,
   output logic       txd,
   input  logic       rxd
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam int            AW        = $clog2(RX_DEPTH);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(RX_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   // ---------------------------------------------------------------------
   // Bus strobe edge detection
   // ---------------------------------------------------------------------
   logic rdn_q, wrn_q;
   logic rd_req, wr_req;

   // Delay the strobes one cycle so their rising edges can be found.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rdn_q <= 1'b1;
         wrn_q <= 1'b1;
      end else begin
         rdn_q <= rdn;
         wrn_q <= wrn;
      end
   end

   assign rd_req = rdn & ~rdn_q;
   assign wr_req = wrn & ~wrn_q;

   // ---------------------------------------------------------------------
   // Transmitter
   // ---------------------------------------------------------------------
   logic [1:0]    tx_state, tx_next;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift, thr;
   logic          thr_full, tsre_q;
   logic          tx_load, txd_int;
   logic          tx_bit_end;

   assign tx_bit_end = (tx_cnt == BIT_LAST);

   // TX state register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) tx_state <= S_IDLE;
      else      tx_state <= tx_next;
   end

   // TX next state; a full THR at the end of STOP chains straight into START.
   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         S_IDLE:  if (thr_full) tx_next = S_START;
         S_START: if (tx_bit_end) tx_next = S_DATA;
         S_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = S_STOP;
         S_STOP:  if (tx_bit_end) tx_next = thr_full ? S_START : S_IDLE;
         default: tx_next = S_IDLE;
      endcase
   end

   // TX outputs: line level and shift-register load strobe.
   always_comb begin
      txd_int = 1'b1;
      tx_load = 1'b0;
      case (tx_state)
         S_IDLE:  tx_load = thr_full;
         S_START: txd_int = 1'b0;
         S_DATA:  txd_int = tx_shift[0];
         S_STOP:  tx_load = tx_bit_end & thr_full;
         default: txd_int = 1'b1;
      endcase
   end

   // TX datapath: bit timer, shifter, holding register and empty flags.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tx_cnt   <= '0;
         tx_bit   <= 3'd0;
         tx_shift <= 8'h00;
         thr      <= 8'h00;
         thr_full <= 1'b0;
         tsre_q   <= 1'b1;
      end else begin
         if (tx_load) begin
            tx_shift <= thr;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tsre_q   <= 1'b0;
         end else begin
            if (tx_state == S_IDLE || tx_bit_end) tx_cnt <= '0;
            else                                   tx_cnt <= tx_cnt + 1'b1;
            if (tx_state == S_DATA && tx_bit_end) begin
               tx_shift <= {1'b0, tx_shift[7:1]};
               tx_bit   <= tx_bit + 3'd1;
            end
            if (tx_state == S_STOP && tx_bit_end) tsre_q <= 1'b1;
         end
         // Load only happens with THR full, writes only land with THR empty.
         if (tx_load) begin
            thr_full <= 1'b0;
         end else if (wr_req && !thr_full) begin
            thr      <= bus_data_in;
            thr_full <= 1'b1;
         end
      end
   end

   assign txd  = txd_int;
   assign tbre = ~thr_full;
   assign tsre = tsre_q;

   // ---------------------------------------------------------------------
   // Receiver
   // ---------------------------------------------------------------------
   logic          rx_src, rx_meta, rx_sync, rx_prev;
   logic [1:0]    rx_state, rx_next;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_bit_end, rx_half, rx_push_req;

`ifdef UART_RESP_LOOPBACK_EN
   assign rx_src = txd_int;
`else
   assign rx_src = rxd;
`endif

   // Two-flop synchronizer plus one history flop for falling-edge detect.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_src;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign rx_bit_end = (rx_cnt == BIT_LAST);
   assign rx_half    = (rx_cnt == HALF_LAST);

   // RX state register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) rx_state <= S_IDLE;
      else      rx_state <= rx_next;
   end

   // RX next state; a high mid-start sample is a glitch and is abandoned.
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         S_IDLE:  if (rx_prev && !rx_sync) rx_next = S_START;
         S_START: if (rx_half) rx_next = rx_sync ? S_IDLE : S_DATA;
         S_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_next = S_STOP;
         S_STOP:  if (rx_bit_end) rx_next = S_IDLE;
         default: rx_next = S_IDLE;
      endcase
   end

   // RX output: a byte is offered to the FIFO on a valid (high) stop sample.
   always_comb begin
      rx_push_req = 1'b0;
      if (rx_state == S_STOP) rx_push_req = rx_bit_end & rx_sync;
   end

   // RX datapath: sample timer and LSB-first deserializer.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_cnt   <= '0;
         rx_bit   <= 3'd0;
         rx_shift <= 8'h00;
      end else begin
         case (rx_state)
            S_START: rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
            S_DATA, S_STOP: rx_cnt <= rx_bit_end ? '0 : rx_cnt + 1'b1;
            default: rx_cnt <= '0;
         endcase
         if (rx_state == S_IDLE) rx_bit <= 3'd0;
         if (rx_state == S_DATA && rx_bit_end) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // RX FIFO
   // ---------------------------------------------------------------------
   logic [7:0]    mem [RX_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_next;
   logic          fifo_full, push, pop;
   logic          ready_q, overrun_q;

   assign fifo_full = (count == FULL_CNT);
   assign pop       = rd_req & (count != '0);
   assign push      = rx_push_req & (~fifo_full | pop);

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_next = count;
      if (push && !pop)      count_next = count + 1'b1;
      else if (pop && !push) count_next = count - 1'b1;
   end

   // FIFO storage; contents are don't-care until pushed.
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= rx_shift;
   end

   // FIFO pointers, count, registered ready flag and sticky overrun.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ready_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count   <= count_next;
         ready_q <= (count_next != '0);
         if (rx_push_req && fifo_full && !pop) overrun_q <= 1'b1;
      end
   end

   assign data_ready   = ready_q;
   assign rx_overrun   = overrun_q;
   assign bus_data_out = (count != '0) ? mem[rd_ptr] : 8'h00;
   assign bus_data_oe  = ~rdn & RST;

endmodule

`default_nettype wire

// File: tb/tb_uart_bus_responder.sv
// ============================================================================
// Module   : tb_uart_bus_responder
// Purpose  : Self-checking bench for uart_bus_responder (CLKS_PER_BIT=4,
//            RX_DEPTH=4) using directed vectors and a txd capture log.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_bus_responder;

   localparam int CPB = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       rdn = 1'b1;
   logic       wrn = 1'b1;
   logic       rxd = 1'b1;
   logic [7:0] bus_data_in = 8'h00;
   logic [7:0] bus_data_out;
   logic       bus_data_oe, data_ready, tbre, tsre, rx_overrun, txd;

   int errors = 0;
   int checks = 0;

   uart_bus_responder #(.CLKS_PER_BIT(CPB), .RX_DEPTH(4)) dut (
      .CLK(CLK), .RST(RST), .rdn(rdn), .wrn(wrn),
      .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
      .bus_data_oe(bus_data_oe), .data_ready(data_ready),
      .tbre(tbre), .tsre(tsre), .rx_overrun(rx_overrun),
      .txd(txd), .rxd(rxd)
   );

   always #5 CLK = ~CLK;

   // txd capture, one sample per cycle on the falling edge
   logic log_en = 1'b0;
   logic txq[$];
   always @(negedge CLK) if (log_en) txq.push_back(txd);

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_ready;
   } rx_vec_t;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [7:0] b);
      @(negedge CLK);
      bus_data_in = b;
      wrn = 1'b0;
      @(negedge CLK);
      wrn = 1'b1;
   endtask

   task automatic bus_read(output logic [7:0] d, output logic oe);
      @(negedge CLK);
      rdn = 1'b0;
      #1;
      d  = bus_data_out;
      oe = bus_data_oe;
      @(negedge CLK);
      rdn = 1'b1;
      @(negedge CLK);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      @(negedge CLK);
      for (int i = 0; i < 10; i++) begin
         rxd = fr[i];
         repeat (CPB) @(negedge CLK);
      end
      rxd = 1'b1;
      repeat (6) @(negedge CLK);
   endtask

   task automatic wait_tsre(input string name);
      int n;
      n = 0;
      while (tsre !== 1'b1 && n < 300) begin
         @(negedge CLK);
         n++;
      end
      check8(name, {7'b0, tsre}, 8'h01);
   endtask

   // Compare the captured txd log against nframes back-to-back 8N1 frames.
   task automatic check_tx_log(input logic [7:0] b0, input logic [7:0] b1, input int nframes);
      int         k;
      int         idx;
      logic       act, exp;
      logic [9:0] fr;
      logic [7:0] bad;
      k = -1;
      for (int i = 0; i < txq.size(); i++) begin
         if (txq[i] === 1'b0) begin
            k = i;
            break;
         end
      end
      check8("tx_start_seen", {7'b0, (k >= 0)}, 8'h01);
      if (k < 0) return;
      for (int f = 0; f < nframes; f++) begin
         fr = {1'b1, (f == 0) ? b0 : b1, 1'b0};
         for (int b = 0; b < 10; b++) begin
            exp = fr[b];
            act = exp;
            for (int c = 0; c < CPB; c++) begin
               idx = k + f * 10 * CPB + b * CPB + c;
               if (idx >= txq.size()) act = 1'bx;
               else if (txq[idx] !== exp) act = txq[idx];
            end
            check8($sformatf("tx_f%0d_bit%0d", f, b), {7'b0, act}, {7'b0, exp});
         end
      end
      bad = 8'h00;
      for (int i = k + nframes * 10 * CPB; i < txq.size(); i++)
         if (txq[i] !== 1'b1) bad = 8'h01;
      check8("tx_idle_after", bad, 8'h00);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rx_vec_t    vecs[5];
      logic [7:0] d;
      logic       oe;
      int         n;
      logic [7:0] zeros;

      vecs[0] = '{8'h96, 1'b1, 1'b1};
      vecs[1] = '{8'h00, 1'b1, 1'b1};
      vecs[2] = '{8'hFF, 1'b1, 1'b1};
      vecs[3] = '{8'h5A, 1'b0, 1'b0};
      vecs[4] = '{8'h81, 1'b1, 1'b1};

      // ---- reset with random strobes and line activity
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         rxd = 1'($urandom_range(0, 1));
         rdn = 1'($urandom_range(0, 1));
         wrn = 1'($urandom_range(0, 1));
         #1;
         check8("reset_flags", {2'b00, txd, tbre, tsre, data_ready, bus_data_oe, rx_overrun},
                8'b0011_1000);
         check8("reset_bus_out", bus_data_out, 8'h00);
      end
      @(negedge CLK);
      rxd = 1'b1; rdn = 1'b1; wrn = 1'b1;
      @(negedge CLK);
      RST = 1'b1;
      repeat (3) @(negedge CLK);

      // ---- single TX frame 8'hA5
      txq.delete();
      log_en = 1'b1;
      bus_write(8'hA5);
      @(negedge CLK);
      check8("tx_tbre_after_write", {7'b0, tbre}, 8'h00);
      @(negedge CLK);
      check8("tx_load_flags", {5'b0, tbre, tsre, txd}, 8'b0000_0100);
      wait_tsre("tx_tsre_end");
      repeat (8) @(negedge CLK);
      log_en = 1'b0;
      check_tx_log(8'hA5, 8'h00, 1);

      // ---- back-to-back TX, third write dropped
      txq.delete();
      log_en = 1'b1;
      bus_write(8'h3C);
      n = 0;
      while (tbre !== 1'b1 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check8("b2b_tbre_reload", {7'b0, tbre}, 8'h01);
      bus_write(8'h5A);
      @(negedge CLK);
      check8("b2b_tbre_busy", {7'b0, tbre}, 8'h00);
      bus_write(8'hFF);
      wait_tsre("b2b_tsre_end");
      repeat (8) @(negedge CLK);
      log_en = 1'b0;
      check_tx_log(8'h3C, 8'h5A, 2);

      // ---- reset mid-frame aborts transmission
      bus_write(8'hA5);
      repeat (10) @(negedge CLK);
      RST = 1'b0;
      #1;
      check8("midreset_flags", {5'b0, txd, tbre, tsre}, 8'b0000_0111);
      @(negedge CLK);
      RST = 1'b1;
      zeros = 8'h00;
      repeat (60) begin
         @(negedge CLK);
         if (txd !== 1'b1) zeros = 8'h01;
      end
      check8("midreset_line_idle", zeros, 8'h00);

`ifdef UART_RESP_LOOPBACK_EN
      // ---- loopback: transmitted byte lands in the RX FIFO
      do_reset();
      bus_write(8'hC3);
      n = 0;
      while (data_ready !== 1'b1 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check8("loop_ready", {7'b0, data_ready}, 8'h01);
      bus_read(d, oe);
      check8("loop_data", d, 8'hC3);
      check8("loop_ready_after", {7'b0, data_ready}, 8'h00);
`else
      do_reset();
      // ---- RX vector table
      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i].data, vecs[i].stop);
         check8($sformatf("rx%0d_ready", i), {7'b0, data_ready}, {7'b0, vecs[i].exp_ready});
         if (vecs[i].exp_ready) begin
            bus_read(d, oe);
            check8($sformatf("rx%0d_oe", i), {7'b0, oe}, 8'h01);
            check8($sformatf("rx%0d_data", i), d, vecs[i].data);
            check8($sformatf("rx%0d_after", i), {6'b0, data_ready, bus_data_oe}, 8'h00);
         end else begin
            check8($sformatf("rx%0d_bus_out", i), bus_data_out, 8'h00);
         end
      end
      check8("rx_no_overrun_yet", {7'b0, rx_overrun}, 8'h00);

      // ---- overrun: five frames into a four-deep FIFO
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      check8("ovr_flags", {6'b0, data_ready, rx_overrun}, 8'h03);
      for (int i = 1; i <= 5; i++) begin
         bus_read(d, oe);
         check8($sformatf("ovr_read%0d", i), d, (i <= 4) ? 8'(i) : 8'h00);
      end
      check8("ovr_drained", {6'b0, data_ready, rx_overrun}, 8'h01);

      // ---- one-cycle glitch is ignored, receiver stays usable
      @(negedge CLK);
      rxd = 1'b0;
      @(negedge CLK);
      rxd = 1'b1;
      repeat (20) @(negedge CLK);
      check8("glitch_no_push", {7'b0, data_ready}, 8'h00);
      send_frame(8'h42, 1'b1);
      bus_read(d, oe);
      check8("glitch_next_frame", d, 8'h42);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
